alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 32-bit ALU (opcodes per alu.svh; op 3'b111 reserved) between two requesters.
- Each requester issues an operation with a valid/ready handshake.
- The arbiter registers the operands, drives the ALU for one cycle, captures the result and flags, and returns them on a single response channel tagged with the requester id.
- Sits between the issue stages of two clients and the shared ALU instance.

Parameters:
- WIDTH, 32, datapath width of operands and result; the ALU is 32-bit, so only 32 is supported.
- RR_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_x  in  WIDTH  requester 0 operand x.
- req0_y  in  WIDTH  requester 0 operand y.
- req0_op  in  3  requester 0 opcode.
- req1_valid, req1_ready, req1_x, req1_y, req1_op: same directions and widths as the requester 0 ports, for requester 1.
- alu_x  out  WIDTH  operand x to the ALU.
- alu_y  out  WIDTH  operand y to the ALU.
- alu_op  out  3  opcode to the ALU.
- alu_z  in  WIDTH  result from the ALU.
- alu_equal  in  1  equal flag from the ALU.
- alu_overflow  in  1  overflow flag from the ALU.
- alu_zero  in  1  zero flag from the ALU.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the response.
- rsp_z  out  WIDTH  captured result.
- rsp_flags  out  3  {equal, overflow, zero} captured.
- rsp_err  out  1  opcode was reserved (3'b111).

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset forces IDLE.
- Reset values: every output 0; priority pointer = RR_INIT.
- IDLE:
  - If either valid is high, grant one requester. When both are valid, grant the one the priority pointer names.
  - The granted reqN_ready is high combinationally in this same cycle. At most one ready is high at a time, and ready is only ever high in IDLE.
  - On the handshake (valid & ready), register x, y, op and the id, then go to EXEC.
  - If neither valid is high, remain in IDLE.
- EXEC:
  - alu_x, alu_y and alu_op come from the operand registers. They hold their last values in all states and are never driven directly from the request ports.
  - At the end of EXEC, capture alu_z, the flags, the id and rsp_err = (op == 3'b111) into the response registers. Go to RESP.
- RESP:
  - rsp_valid = 1 and the response fields are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: set the priority pointer to the id that was not just served, drop rsp_valid next cycle and return to IDLE.
- Timing:
  - Minimum latency from request handshake to rsp_valid is 2 cycles.
  - Peak throughput is one operation per 3 cycles.
  - Back-to-back accepts alternate between requesters when both are continuously valid.
- A request's valid may drop before it is granted; a non-granted request is never captured.
- Reserved op: forwarded to the ALU unchanged. The response carries the ALU outputs (expected z = 0, flags = 0) with rsp_err = 1.
- Reset asserted in any state: the next state is IDLE, rsp_valid = 0 and the pointer = RR_INIT. An in-flight operation is discarded and no response is issued for it.
- Response outputs other than rsp_valid hold their last value after the handshake, except that reset clears them to 0.

Test Plan:
- Only req0 valid, ADD x=7FFF_FFFF y=0000_0001, rsp_ready=1 → req0_ready in cycle 0; rsp_valid in cycle 2 with rsp_id=0, rsp_z=8000_0000, flags {0,1,0}, rsp_err=0.
- Both valid continuously, RR_INIT=0, req0 SUB 5-1, req1 AND AAAA_AAAA&5555_5555 → grant order 0,1,0,1. req0 responses z=4; req1 responses z=0 with zero=1.
- rsp_ready held low 5 cycles after rsp_valid → rsp fields stable, both req*_ready stay 0, no new accept until rsp_ready is raised.
- req1 op=3'b111 x=1234_5678 y=1234_5678 → rsp_z=0, flags=000, rsp_err=1, rsp_id=1.
- rst asserted during EXEC of req0 SLT 8000_0000<0000_000F → no response ever appears for that op; next cycle all outputs 0 and state IDLE; a new req1 SRA 8AC3_FB75 by 4 gives rsp_z=F8AC_3FB7.
- req0 valid one cycle while the arbiter is in RESP, then dropped → never accepted, no response for it.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two requesters.
// Each accepted operation is registered, presented to the ALU for one cycle, and its
// result and flags are returned on a single response channel tagged with the requester id.
module alu_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter bit          RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [2:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic [2:0]       req1_op,

    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_equal,
    input  logic             alu_overflow,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_z,
    output logic [2:0]       rsp_flags,
    output logic             rsp_err
);

    localparam logic [2:0] OpReserved = 3'b111;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e state_q, state_d;

    // Priority pointer: names the requester that wins when both are valid.
    logic ptr_q;

    // Operand registers; these feed the ALU directly and hold in every state.
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [2:0]       op_q;
    logic             id_q;

    // Response registers.
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_z_q;
    logic [2:0]       rsp_flags_q;
    logic             rsp_err_q;

    logic grant_any;
    logic grant_id;
    logic accept;
    logic rsp_hs;

    // Pick a winner among the valid requesters; pointer breaks ties.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ptr_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign rsp_hs = rsp_valid & rsp_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs; ready is gated by reset so nothing is accepted while it is asserted.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rst && grant_any) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                end
            end
            StResp:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Capture operands of the granted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            op_q <= '0;
            id_q <= 1'b0;
        end else if (accept) begin
            x_q  <= grant_id ? req1_x  : req0_x;
            y_q  <= grant_id ? req1_y  : req0_y;
            op_q <= grant_id ? req1_op : req0_op;
            id_q <= grant_id;
        end
    end

    // Capture ALU result at the end of EXEC; fields hold after the response is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id_q    <= 1'b0;
            rsp_z_q     <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (state_q == StExec) begin
            rsp_id_q    <= id_q;
            rsp_z_q     <= alu_z;
            rsp_flags_q <= {alu_equal, alu_overflow, alu_zero};
            rsp_err_q   <= (op_q == OpReserved);
        end
    end

    // Hand priority to the requester that was not just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= RR_INIT;
        end else if (rsp_hs) begin
            ptr_q <= ~rsp_id_q;
        end
    end

    assign alu_x     = x_q;
    assign alu_y     = y_q;
    assign alu_op    = op_q;

    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a negedge monitor checks grant decisions against a
// transaction-level model and compares every response with a queued expectation.
module tb_alu_arbiter;

    localparam bit RR = 1'b0;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SRA = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    typedef struct packed {
        logic        id;
        logic [31:0] z;
        logic [2:0]  flags;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [31:0] alu_x, alu_y, alu_z;
    logic [2:0]  alu_op;
    logic        alu_equal, alu_overflow, alu_zero;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [31:0] rsp_z;
    logic [2:0]  rsp_flags;
    logic        rsp_err;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cycle = 0;
    int   acc_cycle = 0;
    int   acc_count = 0;
    bit   busy_m = 1'b0;
    bit   ptr_m = RR;
    rsp_t exp_q[$];
    rsp_t mon_cur, mon_prev, mon_exp;
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic e0, e1, hs_id;
    logic [34:0] ref_r;
    int   grants[$];
    int   nr;
    int   c0;
    rsp_t hold;
    bit   found;

    alu_arbiter #(.WIDTH(32), .RR_INIT(RR)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_z(alu_z), .alu_equal(alu_equal), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_z(rsp_z), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural ALU: returns {z, equal, overflow, zero}; reserved op yields all zeros.
    function automatic logic [34:0] alu_ref(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] op);
        logic [31:0] z;
        logic        ov;
        z  = '0;
        ov = 1'b0;
        case (op)
            OP_ADD: begin z = x + y; ov = (x[31] == y[31]) && (z[31] != x[31]); end
            OP_SUB: begin z = x - y; ov = (x[31] != y[31]) && (z[31] != x[31]); end
            OP_AND: z = x & y;
            OP_OR:  z = x | y;
            OP_XOR: z = x ^ y;
            OP_SLT: z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SRA: z = $unsigned($signed(x) >>> y[4:0]);
            default: return 35'd0;
        endcase
        return {z, (x == y), ov, (z == 32'd0)};
    endfunction

    assign {alu_z, alu_equal, alu_overflow, alu_zero} = alu_ref(alu_x, alu_y, alu_op);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: grant rules, expectation push on accept, response compare/latency/stability.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            busy_m     = 1'b0;
            ptr_m      = RR;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            e0 = !busy_m && req0_valid && (!req1_valid || ptr_m == 1'b0);
            e1 = !busy_m && req1_valid && (!req0_valid || ptr_m == 1'b1);
            check("ready_grant", {62'd0, req1_ready, req0_ready}, {62'd0, e1, e0});
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                hs_id = req1_valid && req1_ready;
                ref_r = hs_id ? alu_ref(req1_x, req1_y, req1_op)
                              : alu_ref(req0_x, req0_y, req0_op);
                mon_exp.id    = hs_id;
                mon_exp.z     = ref_r[34:3];
                mon_exp.flags = ref_r[2:0];
                mon_exp.err   = hs_id ? (req1_op == OP_RSV) : (req0_op == OP_RSV);
                exp_q.push_back(mon_exp);
                busy_m    = 1'b1;
                acc_cycle = cycle;
                acc_count++;
            end
            mon_cur.id    = rsp_id;
            mon_cur.z     = rsp_z;
            mon_cur.flags = rsp_flags;
            mon_cur.err   = rsp_err;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    if (prev_valid && !prev_ready) check("rsp_stable", mon_cur, mon_prev);
                    else check("rsp_latency", cycle - acc_cycle, 64'd2);
                    if (rsp_ready) begin
                        mon_exp = exp_q.pop_front();
                        check("rsp_fields", mon_cur, mon_exp);
                        busy_m = 1'b0;
                        ptr_m  = !mon_exp.id;
                    end
                end
            end
            if (busy_m && (cycle - acc_cycle > 200)) begin
                check("rsp_timeout", 64'd0, 64'd1);
                busy_m = 1'b0;
            end
            prev_valid = rsp_valid;
            prev_ready = rsp_ready;
            mon_prev   = mon_cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_alu_xy"}, {alu_x, alu_y}, 64'd0);
        check({name, "_rsp_z"}, rsp_z, 64'd0);
        check({name, "_ctl"}, {req0_ready, req1_ready, alu_op, rsp_valid, rsp_id, rsp_flags,
                               rsp_err}, 64'd0);
    endtask

    task automatic send(input logic id, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] op);
        if (id) begin req1_x = x; req1_y = y; req1_op = op; req1_valid = 1'b1; end
        else    begin req0_x = x; req0_y = y; req0_op = op; req0_valid = 1'b1; end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((id && req1_ready) || (!id && req0_ready)) begin
                tick();
                if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 64'd0, 64'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input logic id, input logic [31:0] z,
                              input logic [2:0] fl, input logic err);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                check({name, "_id"}, rsp_id, id);
                check({name, "_z"}, rsp_z, z);
                check({name, "_flags"}, rsp_flags, fl);
                check({name, "_err"}, rsp_err, err);
                return;
            end
        end
        check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid && !busy_m) done = 1'b1;
        end
        check("drain", done, 64'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");
        tick();

        // Single request, signed overflow on ADD
        rsp_ready = 1'b1;
        send(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, OP_ADD);
        expect_rsp("add_ovf", 1'b0, 32'h8000_0000, 3'b010, 1'b0);
        tick();

        // Both continuously valid after reset: grants alternate starting with RR_INIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_x = 32'd5;          req0_y = 32'd1;          req0_op = OP_SUB;
        req1_x = 32'hAAAA_AAAA;  req1_y = 32'h5555_5555;  req1_op = OP_AND;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        grants.delete();
        nr = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) grants.push_back(0);
            if (req1_valid && req1_ready) grants.push_back(1);
            if (rsp_valid) begin
                check("rr_rsp_id", rsp_id, nr % 2);
                check("rr_rsp_z", rsp_z, (nr % 2 == 1) ? 64'd0 : 64'd4);
                check("rr_rsp_flags", rsp_flags, (nr % 2 == 1) ? 64'd1 : 64'd0);
                nr++;
            end
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr_grant_count", grants.size(), 64'd4);
        foreach (grants[k]) check("rr_grant_order", grants[k], k % 2);
        check("rr_rsp_count", nr, 64'd4);
        drain();

        // Back-pressure: response held while rsp_ready is low, no new accepts
        rsp_ready = 1'b0;
        send(1'b0, 32'h10, 32'h10, OP_XOR);
        req0_x = 32'h00F0;  req0_y = 32'h0F00;  req0_op = OP_OR;  req0_valid = 1'b1;
        req1_x = 32'd3;     req1_y = 32'd9;     req1_op = OP_ADD; req1_valid = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        check("hold_seen", found, 64'd1);
        hold = {rsp_id, rsp_z, rsp_flags, rsp_err};
        check("hold_value", hold, {1'b0, 32'd0, 3'b101, 1'b0});
        c0 = acc_count;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_fields", {rsp_id, rsp_z, rsp_flags, rsp_err}, hold);
            check("hold_ready", {req1_ready, req0_ready}, 64'd0);
            check("hold_valid", rsp_valid, 64'd1);
        end
        check("hold_no_accept", acc_count - c0, 64'd0);
        tick();
        rsp_ready = 1'b1;
        repeat (10) tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Reserved opcode
        send(1'b1, 32'h1234_5678, 32'h1234_5678, OP_RSV);
        expect_rsp("reserved", 1'b1, 32'd0, 3'b000, 1'b1);
        tick();
        drain();

        // Reset during EXEC discards the operation
        send(1'b0, 32'h8000_0000, 32'h0000_000F, OP_SLT);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("exec_reset");
        tick();
        c0 = acc_count;
        send(1'b1, 32'h8AC3_FB75, 32'd4, OP_SRA);
        expect_rsp("sra_after_reset", 1'b1, 32'hF8AC_3FB7, 3'b000, 1'b0);
        tick();
        drain();
        check("sra_single_accept", acc_count - c0, 64'd1);

        // A request pulsed while in RESP is never taken
        rsp_ready = 1'b0;
        send(1'b1, 32'd3, 32'd5, OP_OR);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        check("pulse_rsp_seen", found, 64'd1);
        tick();
        c0 = acc_count;
        req0_x = 32'd1; req0_y = 32'd2; req0_op = OP_ADD; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        rsp_ready = 1'b1;
        drain();
        repeat (5) tick();
        check("pulse_not_taken", acc_count - c0, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_op    = 3'($urandom_range(0, 7));
            req1_op    = 3'($urandom_range(0, 7));
            req0_x     = $urandom;
            req1_x     = $urandom;
            req0_y     = ($urandom_range(0, 3) == 0) ? req0_x : $urandom;
            req1_y     = ($urandom_range(0, 3) == 0) ? req1_x : $urandom;
            rsp_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
